// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller:
// FSM state encoding, coin codes with their credit values, default prices.
package vend_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StDispense = 2'd1,
      StChange   = 2'd2
   } vend_state_e;

   localparam logic [1:0] CoinNone = 2'b00;
   localparam logic [1:0] Coin5    = 2'b01;
   localparam logic [1:0] Coin10   = 2'b10;
   localparam logic [1:0] Coin20   = 2'b11;

   localparam int unsigned DefPrice0 = 15;
   localparam int unsigned DefPrice1 = 20;
   localparam int unsigned DefPrice2 = 25;
   localparam int unsigned DefPrice3 = 30;

   function automatic logic [7:0] coin_value(input logic [1:0] code);
      logic [7:0] val;
      case (code)
         Coin5:   val = 8'd5;
         Coin10:  val = 8'd10;
         Coin20:  val = 8'd20;
         default: val = 8'd0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Loadable down-counter guarding the dispenser handshake; expired is high
// once the count has run down to zero.
module vend_timeout_ctr #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [Width-1:0] load_val,
   output logic             expired
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: accumulates credit, dispatches a product
// selection through the dispenser handshake, then pays change coin by coin.
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int unsigned PRICE0       = DefPrice0,
   parameter int unsigned PRICE1       = DefPrice1,
   parameter int unsigned PRICE2       = DefPrice2,
   parameter int unsigned PRICE3       = DefPrice3,
   parameter int unsigned DISP_TIMEOUT = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_valid,
   input  logic [1:0] coin_code,
   input  logic       sel_valid,
   input  logic [1:0] sel_item,
   input  logic       cancel,
   input  logic       disp_done,
   input  logic       chg_ack,
   output logic [7:0] credit,
   output logic       disp_req,
   output logic [1:0] disp_item,
   output logic       chg_req,
   output logic       chg_coin,
   output logic       coin_reject,
   output logic       err_funds,
   output logic       fault,
   output logic       busy
);

   localparam int unsigned CtrW = $clog2(DISP_TIMEOUT + 1);
   // Loaded on entry so that expiry lands on the DISP_TIMEOUT-th cycle in DISPENSE.
   localparam logic [CtrW-1:0] TmoLoad = CtrW'(DISP_TIMEOUT - 1);

   localparam logic [7:0] Price0 = 8'(PRICE0);
   localparam logic [7:0] Price1 = 8'(PRICE1);
   localparam logic [7:0] Price2 = 8'(PRICE2);
   localparam logic [7:0] Price3 = 8'(PRICE3);

   vend_state_e state_q, state_d;
   logic [7:0]  credit_q, credit_d;
   logic [1:0]  disp_item_q, disp_item_d;
   logic        disp_req_q, disp_req_d;
   logic        chg_req_q, chg_req_d;
   logic        chg_coin_q, chg_coin_d;
   logic        coin_reject_q, coin_reject_d;
   logic        err_funds_q, err_funds_d;
   logic        fault_q, fault_d;

   logic        coin_live;
   logic [7:0]  coin_val;
   logic [8:0]  coin_sum;
   logic [7:0]  eff;
   logic [7:0]  price_sel;
   logic [7:0]  price_disp;
   logic [8:0]  refund;
   logic        ack_taken;
   logic        tmo_load;
   logic        tmo_en;
   logic        tmo_expired;

   vend_timeout_ctr #(
      .Width (CtrW)
   ) u_timeout_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (tmo_load),
      .en       (tmo_en),
      .load_val (TmoLoad),
      .expired  (tmo_expired)
   );

   assign tmo_load = (state_q != StDispense) && (state_d == StDispense);
   assign tmo_en   = (state_q == StDispense);

   always_comb begin
      case (sel_item)
         2'd0:    price_sel = Price0;
         2'd1:    price_sel = Price1;
         2'd2:    price_sel = Price2;
         default: price_sel = Price3;
      endcase
      case (disp_item_q)
         2'd0:    price_disp = Price0;
         2'd1:    price_disp = Price1;
         2'd2:    price_disp = Price2;
         default: price_disp = Price3;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      disp_item_d   = disp_item_q;
      coin_reject_d = 1'b0;
      err_funds_d   = 1'b0;
      fault_d       = 1'b0;
      ack_taken     = 1'b0;
      coin_val      = coin_value(coin_code);
      coin_live     = coin_valid && (coin_code != CoinNone);
      coin_sum      = {1'b0, credit_q} + {1'b0, coin_val};
      eff           = credit_q;
      refund        = {1'b0, credit_q} + {1'b0, price_disp};

      case (state_q)
         StIdle: begin
            if (cancel) begin
               coin_reject_d = coin_live;
               if (credit_q != 8'd0) begin
                  state_d = StChange;
               end
            end else begin
               // Same-cycle coin is credited before the selection is priced.
               if (coin_live) begin
                  if (coin_sum[8]) begin
                     coin_reject_d = 1'b1;
                  end else begin
                     eff = coin_sum[7:0];
                  end
               end
               credit_d = eff;
               if (sel_valid) begin
                  if (eff >= price_sel) begin
                     credit_d    = eff - price_sel;
                     disp_item_d = sel_item;
                     state_d     = StDispense;
                  end else begin
                     err_funds_d = 1'b1;
                  end
               end
            end
         end
         StDispense: begin
            coin_reject_d = coin_live;
            if (disp_done) begin
               state_d = (credit_q != 8'd0) ? StChange : StIdle;
            end else if (tmo_expired) begin
               fault_d  = 1'b1;
               credit_d = refund[8] ? 8'hFF : refund[7:0];
               state_d  = StChange;
            end
         end
         StChange: begin
            coin_reject_d = coin_live;
            if (credit_q < 8'd5) begin
               credit_d = 8'd0;
               state_d  = StIdle;
            end else if (chg_req_q && chg_ack) begin
               ack_taken = 1'b1;
               credit_d  = credit_q - (chg_coin_q ? 8'd10 : 8'd5);
               if (credit_d == 8'd0) begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d  = StIdle;
            credit_d = 8'd0;
         end
      endcase

      // Request drops for the cycle after each ack so the next coin choice settles.
      chg_req_d  = (state_d == StChange) && !ack_taken;
      chg_coin_d = (credit_d >= 8'd10);
      disp_req_d = (state_d == StDispense);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         credit_q      <= 8'd0;
         disp_item_q   <= 2'd0;
         disp_req_q    <= 1'b0;
         chg_req_q     <= 1'b0;
         chg_coin_q    <= 1'b0;
         coin_reject_q <= 1'b0;
         err_funds_q   <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         disp_item_q   <= disp_item_d;
         disp_req_q    <= disp_req_d;
         chg_req_q     <= chg_req_d;
         chg_coin_q    <= chg_coin_d;
         coin_reject_q <= coin_reject_d;
         err_funds_q   <= err_funds_d;
         fault_q       <= fault_d;
      end
   end

   assign credit      = credit_q;
   assign disp_req    = disp_req_q;
   assign disp_item   = disp_item_q;
   assign chg_req     = chg_req_q;
   assign chg_coin    = chg_coin_q;
   assign coin_reject = coin_reject_q;
   assign err_funds   = err_funds_q;
   assign fault       = fault_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed scoreboard bench for vend_sequencer: expectations are queued as
// stimulus is driven and popped against DUT outputs sampled 1 time unit after each edge.
module tb_vend_sequencer;

   localparam int unsigned T = 200;
   localparam logic [1:0] C5  = 2'b01;
   localparam logic [1:0] C10 = 2'b10;
   localparam logic [1:0] C20 = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_code = 2'b00;
   logic       sel_valid = 1'b0;
   logic [1:0] sel_item = 2'b00;
   logic       cancel = 1'b0;
   logic       disp_done = 1'b0;
   logic       chg_ack = 1'b0;
   logic [7:0] credit;
   logic       disp_req;
   logic [1:0] disp_item;
   logic       chg_req;
   logic       chg_coin;
   logic       coin_reject;
   logic       err_funds;
   logic       fault;
   logic       busy;

   vend_sequencer #(
      .PRICE0       (15),
      .PRICE1       (20),
      .PRICE2       (25),
      .PRICE3       (30),
      .DISP_TIMEOUT (T)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .coin_valid  (coin_valid),
      .coin_code   (coin_code),
      .sel_valid   (sel_valid),
      .sel_item    (sel_item),
      .cancel      (cancel),
      .disp_done   (disp_done),
      .chg_ack     (chg_ack),
      .credit      (credit),
      .disp_req    (disp_req),
      .disp_item   (disp_item),
      .chg_req     (chg_req),
      .chg_coin    (chg_coin),
      .coin_reject (coin_reject),
      .err_funds   (err_funds),
      .fault       (fault),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [15:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic pop(input logic [15:0] obs);
      exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty observed=%0d required=<queued expectation>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val)
         else begin
            n_fail++;
            $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic pulse(input logic cv, input logic [1:0] cc, input logic sv,
                        input logic [1:0] si, input logic cn, input logic dd, input logic ca);
      coin_valid = cv;
      coin_code  = cc;
      sel_valid  = sv;
      sel_item   = si;
      cancel     = cn;
      disp_done  = dd;
      chg_ack    = ca;
      tick();
      coin_valid = 1'b0;
      coin_code  = 2'b00;
      sel_valid  = 1'b0;
      sel_item   = 2'b00;
      cancel     = 1'b0;
      disp_done  = 1'b0;
      chg_ack    = 1'b0;
   endtask

   task automatic coin(input logic [1:0] cc, input int exp_credit);
      push("credit_after_coin", 16'(exp_credit));
      pulse(1'b1, cc, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      pop(16'(credit));
   endtask

   // Waits (bounded) for chg_req, checks the coin choice, acks, checks credit.
   task automatic serve_coin(input logic exp_coin, input int exp_credit);
      int n = 0;
      push("chg_req_coin", {14'd0, 1'b1, exp_coin});
      push("credit_after_ack", 16'(exp_credit));
      push("chg_req_drop", 16'd0);
      while (!chg_req && n < 20) begin
         tick();
         n++;
      end
      pop({14'd0, chg_req, chg_coin});
      pulse(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      pop(16'(credit));
      pop({15'd0, chg_req});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;

      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      push("rst_credit", 16'd0);
      pop(16'(credit));
      push("rst_busy", 16'd0);
      pop({15'd0, busy});
      push("rst_disp_req", 16'd0);
      pop({15'd0, disp_req});
      push("rst_chg_req", 16'd0);
      pop({15'd0, chg_req});

      // Ignored inputs in IDLE: valid coin code 00, stray done/ack, cancel at zero credit
      push("code00_credit", 16'd0);
      push("code00_reject", 16'd0);
      pulse(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
      pop(16'(credit));
      pop({15'd0, coin_reject});
      push("cancel_zero_busy", 16'd0);
      pulse(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      pop({15'd0, busy});

      // 10+10, buy item0, dispense, one 5-coin change
      coin(C10, 10);
      coin(C10, 20);
      push("sel0_credit", 16'd5);
      push("sel0_req_item", 16'd4);
      push("sel0_busy", 16'd1);
      pulse(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      pop(16'(credit));
      pop({13'd0, disp_req, disp_item});
      pop({15'd0, busy});
      tick();
      tick();
      push("disp_req_hold", 16'd1);
      pop({15'd0, disp_req});
      push("done_disp_req", 16'd0);
      push("done_chg", 16'd2);
      pulse(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      pop({15'd0, disp_req});
      pop({14'd0, chg_req, chg_coin});
      serve_coin(1'b0, 0);
      push("t1_busy_end", 16'd0);
      pop({15'd0, busy});

      // Insufficient funds, then same-cycle coin+select
      coin(C10, 10);
      push("errf_pulse", 16'd1);
      push("errf_credit", 16'd10);
      push("errf_busy", 16'd0);
      pulse(1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      pop({15'd0, err_funds});
      pop(16'(credit));
      pop({15'd0, busy});
      push("errf_one_cycle", 16'd0);
      tick();
      pop({15'd0, err_funds});
      push("coinsel_credit", 16'd0);
      push("coinsel_disp_req", 16'd1);
      push("coinsel_reject", 16'd0);
      pulse(1'b1, C5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      pop(16'(credit));
      pop({15'd0, disp_req});
      pop({15'd0, coin_reject});
      push("t2_done_busy", 16'd0);
      push("t2_done_chg_req", 16'd0);
      pulse(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      pop({15'd0, busy});
      pop({15'd0, chg_req});

      // Cancel with 25: change 10, 10, 5
      coin(C20, 20);
      coin(C5, 25);
      push("cancel_busy", 16'd1);
      pulse(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      pop({15'd0, busy});
      serve_coin(1'b1, 15);
      serve_coin(1'b1, 5);
      serve_coin(1'b0, 0);
      push("t3_busy_end", 16'd0);
      pop({15'd0, busy});

      // Dispense timeout with 25 credit, refunded then paid as 10, 10, 5
      coin(C20, 20);
      coin(C5, 25);
      push("sel2_credit", 16'd0);
      push("sel2_req_item", 16'd6);
      pulse(1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      pop(16'(credit));
      pop({13'd0, disp_req, disp_item});
      k = 0;
      while (!fault && k < int'(T) + 20) begin
         tick();
         k++;
      end
      push("timeout_cycles", 16'(T));
      pop(16'(k));
      push("fault_credit", 16'd25);
      push("fault_disp_req", 16'd0);
      push("fault_chg", 16'd3);
      pop(16'(credit));
      pop({15'd0, disp_req});
      pop({14'd0, chg_req, chg_coin});
      push("fault_one_cycle", 16'd0);
      tick();
      pop({15'd0, fault});
      serve_coin(1'b1, 15);
      serve_coin(1'b1, 5);
      serve_coin(1'b0, 0);
      push("t4_busy_end", 16'd0);
      pop({15'd0, busy});

      // Credit ceiling and coins during DISPENSE
      for (int i = 1; i <= 12; i++) begin
         coin(C20, 20 * i);
      end
      coin(C10, 250);
      push("ovf_reject", 16'd1);
      push("ovf_credit", 16'd250);
      pulse(1'b1, C10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      pop({15'd0, coin_reject});
      pop(16'(credit));
      push("reject_one_cycle", 16'd0);
      tick();
      pop({15'd0, coin_reject});
      push("fill255_reject", 16'd0);
      pulse(1'b1, C5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      pop({15'd0, coin_reject});
      push("fill255_credit", 16'd255);
      pop(16'(credit));
      push("sel3_credit", 16'd225);
      pulse(1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
      pop(16'(credit));
      push("disp_coin_reject", 16'd1);
      push("disp_coin_credit", 16'd225);
      push("disp_coin_req", 16'd1);
      pulse(1'b1, C5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      pop({15'd0, coin_reject});
      pop(16'(credit));
      pop({15'd0, disp_req});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push("rst_disp_credit", 16'd0);
      push("rst_disp_req", 16'd0);
      pop(16'(credit));
      pop({15'd0, disp_req});

      // Reset in the middle of CHANGE abandons credit
      coin(C10, 10);
      coin(C5, 15);
      push("chg15_req_coin", 16'd3);
      pulse(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      pop({14'd0, chg_req, chg_coin});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push("midchg_busy", 16'd0);
      push("midchg_credit", 16'd0);
      push("midchg_chg_req", 16'd0);
      pop({15'd0, busy});
      pop(16'(credit));
      pop({15'd0, chg_req});

      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_leftover observed=%0d required=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
